// File: rtl/debug_interface_v2.sv
// -----------------------------------------------------------------------------
// debug_interface_v2
//
// Debug capture port for the VGA control path. While debug mode is enabled,
// every newly validated 9-bit command frame is snapshotted together with the
// 4-bit data register value present at the same clock edge. Both snapshots are
// held on registered outputs for LEDs or a logic analyser. With debug mode
// disabled the outputs read zero and incoming frames are ignored.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous active-high reset
//   debug        in   1  debug mode enable (level)
//   frame_valid  in   1  frame strobe, may be high for one or more cycles
//   frame        in   9  received command frame (opaque)
//   data_out     in   4  current downstream data register contents
//   debug_frame  out  9  last frame captured in debug mode (registered)
//   debug_reg    out  4  data_out captured with that frame (registered)
// -----------------------------------------------------------------------------
module debug_interface_v2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       debug,
    input  logic       frame_valid,
    input  logic [8:0] frame,
    input  logic [3:0] data_out,
    output logic [8:0] debug_frame,
    output logic [3:0] debug_reg
);

    typedef enum logic [0:0] {
        ST_OFF   = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t state_r;
    logic   fv_r;       // registered copy of frame_valid
    logic   fv_rise_s;  // first cycle of a frame_valid pulse

    // One capture per pulse, however long frame_valid stays high.
    assign fv_rise_s = frame_valid & ~fv_r;

    // Mode FSM, strobe history and captured outputs. Capture is decided by
    // debug as sampled at this edge rather than by the current state, so a
    // strobe coinciding with debug rising is still captured and a strobe
    // coinciding with debug falling is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_OFF;
            fv_r        <= 1'b0;
            debug_frame <= 9'h000;
            debug_reg   <= 4'h0;
        end else begin
            fv_r <= frame_valid;

            case (state_r)
                ST_OFF: begin
                    if (debug) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_OFF;
                    end
                end
                ST_ARMED: begin
                    if (debug) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_OFF;
                    end
                end
                default: begin
                    state_r <= ST_OFF;
                end
            endcase

            if (!debug) begin
                debug_frame <= 9'h000;
                debug_reg   <= 4'h0;
            end else if (fv_rise_s) begin
                debug_frame <= frame;
                debug_reg   <= data_out;
            end else begin
                debug_frame <= debug_frame;
                debug_reg   <= debug_reg;
            end
        end
    end

endmodule

// File: tb/tb_debug_interface_v2.sv
// -----------------------------------------------------------------------------
// tb_debug_interface_v2
//
// Scoreboard bench for debug_interface_v2. The stimulus process drives inputs
// just after each rising edge and pushes the outputs it expects that edge to
// have produced; a separate monitor pops one entry per falling edge and
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_debug_interface_v2;

    logic       clk;
    logic       rst;
    logic       debug;
    logic       frame_valid;
    logic [8:0] frame;
    logic [3:0] data_out;
    logic [8:0] debug_frame;
    logic [3:0] debug_reg;

    typedef struct {
        logic [8:0] f;
        logic [3:0] r;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    debug_interface_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .debug       (debug),
        .frame_valid (frame_valid),
        .frame       (frame),
        .data_out    (data_out),
        .debug_frame (debug_frame),
        .debug_reg   (debug_reg)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare one expected entry per falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_total = n_total + 1;
            if (debug_frame === e.f && debug_reg === e.r) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL %s: got debug_frame=%h debug_reg=%h, required debug_frame=%h debug_reg=%h",
                         e.name, debug_frame, debug_reg, e.f, e.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [8:0] f, input logic [3:0] r, input string name);
        exp_t e;
        e.f    = f;
        e.r    = r;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        int guard;
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        debug       = 1'b0;
        frame_valid = 1'b0;
        frame       = 9'h000;
        data_out    = 4'h0;

        // Reset
        tick(); expect_out(9'h000, 4'h0, "reset_active");
        rst = 1'b0;
        tick(); expect_out(9'h000, 4'h0, "reset_release");

        // Debug disabled: strobe ignored
        frame = 9'b010101010; data_out = 4'hA; frame_valid = 1'b1;
        tick(); expect_out(9'h000, 4'h0, "dis_strobe");
        frame_valid = 1'b0;
        tick(); expect_out(9'h000, 4'h0, "dis_after");

        // Debug rises on the same edge as the strobe: captured
        debug = 1'b1; frame = 9'b010110011; data_out = 4'h3; frame_valid = 1'b1;
        tick(); expect_out(9'b010110011, 4'h3, "en_capture");
        frame_valid = 1'b0; frame = 9'h000; data_out = 4'hF;
        tick(); expect_out(9'b010110011, 4'h3, "en_hold1");
        tick(); expect_out(9'b010110011, 4'h3, "en_hold2");

        // Frame plus register, later data_out changes ignored
        frame = 9'b001010101; data_out = 4'b0101; frame_valid = 1'b1;
        tick(); expect_out(9'b001010101, 4'b0101, "frame_reg_capture");
        frame_valid = 1'b0; data_out = 4'hC;
        tick(); expect_out(9'b001010101, 4'b0101, "reg_hold1");
        data_out = 4'h9;
        tick(); expect_out(9'b001010101, 4'b0101, "reg_hold2");

        // Long strobe: only the first cycle is captured
        frame = 9'h1A1; data_out = 4'h7; frame_valid = 1'b1;
        tick(); expect_out(9'h1A1, 4'h7, "long_first");
        for (int i = 1; i < 5; i++) begin
            frame    = 9'h100 + 9'(i);
            data_out = 4'(i);
            tick(); expect_out(9'h1A1, 4'h7, "long_hold");
        end
        frame_valid = 1'b0;
        tick(); expect_out(9'h1A1, 4'h7, "long_end");

        // Back-to-back 1,0,1: two captures two cycles apart
        frame = 9'h0F0; data_out = 4'h1; frame_valid = 1'b1;
        tick(); expect_out(9'h0F0, 4'h1, "b2b_first");
        frame = 9'h111; data_out = 4'h2; frame_valid = 1'b0;
        tick(); expect_out(9'h0F0, 4'h1, "b2b_gap");
        frame = 9'h1FF; data_out = 4'hE; frame_valid = 1'b1;
        tick(); expect_out(9'h1FF, 4'hE, "b2b_second");
        frame_valid = 1'b0;
        tick(); expect_out(9'h1FF, 4'hE, "b2b_hold");

        // Debug drops on the same edge as a strobe: clear, no capture
        debug = 1'b0; frame = 9'h055; data_out = 4'h4; frame_valid = 1'b1;
        tick(); expect_out(9'h000, 4'h0, "drop_clear");
        frame_valid = 1'b0;
        tick(); expect_out(9'h000, 4'h0, "drop_idle");

        // frame_valid already high when debug rises: no capture until next pulse
        frame = 9'h0C3; data_out = 4'hB; frame_valid = 1'b1;
        tick(); expect_out(9'h000, 4'h0, "off_fv_high");
        debug = 1'b1;
        tick(); expect_out(9'h000, 4'h0, "armed_no_cap");
        frame_valid = 1'b0;
        tick(); expect_out(9'h000, 4'h0, "rearm_idle");
        frame = 9'h0AA; data_out = 4'h6; frame_valid = 1'b1;
        tick(); expect_out(9'h0AA, 4'h6, "rearm_capture");
        frame_valid = 1'b0;
        tick(); expect_out(9'h0AA, 4'h6, "rearm_hold");

        // Asynchronous reset between edges clears outputs immediately
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_out(9'h000, 4'h0, "async_rst");
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick(); expect_out(9'h000, 4'h0, "post_rst");
        frame = 9'h133; data_out = 4'h9; frame_valid = 1'b1;
        tick(); expect_out(9'h133, 4'h9, "post_rst_capture");
        frame_valid = 1'b0;

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard = guard + 1;
        end
        #1;
        if (sb.size() > 0) begin
            n_total = n_total + 1;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
